// File: rtl/sb_tx_packer_pkg.sv
// Shared types and constants for the switchboard TX packer.
package sb_tx_packer_pkg;

   localparam int SB_DW    = 256;
   localparam int SB_DESTW = 32;

   typedef enum logic {FILL, SEND} state_t;

   typedef struct packed {
      logic [SB_DW-1:0]    data;
      logic [SB_DESTW-1:0] dest;
      logic                last;
   } word_t;

endpackage

// File: rtl/sb_tx_packer_wbuf.sv
// One SB word buffer: lane writes, close (latch dest/last, mark valid),
// and clear back to PAD once the word has been handed off.
module sb_tx_packer_wbuf
   import sb_tx_packer_pkg::*;
#(
   parameter int             IW   = 8,
   parameter int             IDXW = 5,
   parameter logic [IW-1:0]  PAD  = 8'h00
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr,
   input  logic [IDXW-1:0]     wr_idx,
   input  logic [IW-1:0]       wr_data,
   input  logic                close,
   input  logic                close_last,
   input  logic [SB_DESTW-1:0] close_dest,
   input  logic                clr,
   output word_t               word,
   output logic                valid
);

   localparam logic [SB_DW-1:0] PAD_WORD = {(SB_DW/IW){PAD}};

   always_ff @(posedge clk) begin
      if (reset) begin
         word.data <= PAD_WORD;
         word.dest <= '0;
         word.last <= 1'b0;
         valid     <= 1'b0;
      end else begin
         if (clr) begin
            word.data <= PAD_WORD;
            valid     <= 1'b0;
         end
         if (wr)
            word.data[wr_idx*IW +: IW] <= wr_data;
         if (close) begin
            valid     <= 1'b1;
            word.dest <= close_dest;
            word.last <= close_last;
         end
      end
   end

endmodule

// File: rtl/sb_tx_packer.sv
// Packs an IW-bit lane stream into SB words with valid/ready/last/dest.
// Define SB_TX_PACKER_SKID_EN for a ping-pong pair of word buffers.
module sb_tx_packer
   import sb_tx_packer_pkg::*;
#(
   parameter int            DW    = 256,
   parameter int            IW    = 8,
   parameter int            DESTW = 32,
   parameter logic [IW-1:0] PAD   = 8'h00
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IW-1:0]    in_data,
   input  logic             in_last,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DESTW-1:0] cfg_dest,
   output logic [DW-1:0]    sb_tx_data,
   output logic [DESTW-1:0] sb_tx_dest,
   output logic             sb_tx_last,
   output logic             sb_tx_valid,
   input  logic             sb_tx_ready,
   output logic [31:0]      words_sent
);

   localparam int N    = DW / IW;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

   logic [IDXW-1:0]  idx_q;
   logic             first_q;
   logic [DESTW-1:0] dest_q;
   logic [31:0]      words_q;
   logic             accept, close, hs;
   logic [DESTW-1:0] lane_dest;
   word_t            out_word;

   assign accept    = in_valid & in_ready;
   assign close     = accept & (in_last | (idx_q == LAST_IDX));
   assign hs        = sb_tx_valid & sb_tx_ready;
   // A one-lane packet closes on its first lane, so bypass the dest register.
   assign lane_dest = first_q ? cfg_dest : dest_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q   <= '0;
         first_q <= 1'b1;
         dest_q  <= '0;
         words_q <= '0;
      end else begin
         if (accept) begin
            idx_q   <= close ? '0 : idx_q + 1'b1;
            first_q <= in_last;
            if (first_q)
               dest_q <= cfg_dest;
         end
         if (hs)
            words_q <= words_q + 32'd1;
      end
   end

`ifdef SB_TX_PACKER_SKID_EN
   word_t      word [2];
   logic [1:0] valid;
   logic       wr_sel_q, rd_sel_q;

   for (genvar i = 0; i < 2; i++) begin : g_buf
      sb_tx_packer_wbuf #(.IW(IW), .IDXW(IDXW), .PAD(PAD)) u_wbuf (
         .clk        (clk),
         .reset      (reset),
         .wr         (accept & (wr_sel_q == 1'(i))),
         .wr_idx     (idx_q),
         .wr_data    (in_data),
         .close      (close & (wr_sel_q == 1'(i))),
         .close_last (in_last),
         .close_dest (lane_dest),
         .clr        (hs & (rd_sel_q == 1'(i))),
         .word       (word[i]),
         .valid      (valid[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_sel_q <= 1'b0;
         rd_sel_q <= 1'b0;
      end else begin
         if (close)
            wr_sel_q <= ~wr_sel_q;
         if (hs)
            rd_sel_q <= ~rd_sel_q;
      end
   end

   assign in_ready    = ~valid[wr_sel_q];
   assign sb_tx_valid = valid[rd_sel_q];
   assign out_word    = word[rd_sel_q];
`else
   // state | meaning
   // FILL  | accepting lanes into the word buffer
   // SEND  | word offered downstream, input stalled until handshake
   state_t state_q, state_d;
   logic   valid;

   sb_tx_packer_wbuf #(.IW(IW), .IDXW(IDXW), .PAD(PAD)) u_wbuf (
      .clk        (clk),
      .reset      (reset),
      .wr         (accept),
      .wr_idx     (idx_q),
      .wr_data    (in_data),
      .close      (close),
      .close_last (in_last),
      .close_dest (lane_dest),
      .clr        (hs),
      .word       (out_word),
      .valid      (valid)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= FILL;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      case (state_q)
         FILL: begin
            in_ready = 1'b1;
            if (close)
               state_d = SEND;
         end
         SEND: begin
            if (sb_tx_ready)
               state_d = FILL;
         end
         default: state_d = FILL;
      endcase
   end

   assign sb_tx_valid = valid;
`endif

   assign sb_tx_data = out_word.data[DW-1:0];
   assign sb_tx_dest = out_word.dest[DESTW-1:0];
   assign sb_tx_last = out_word.last;
   assign words_sent = words_q;

endmodule

// File: tb/tb_sb_tx_packer.sv
// Directed self-checking bench for sb_tx_packer (default byte lanes, 256-bit words).
module tb_sb_tx_packer;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   in_data;
   logic         in_last;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  cfg_dest;
   logic [255:0] sb_tx_data;
   logic [31:0]  sb_tx_dest;
   logic         sb_tx_last;
   logic         sb_tx_valid;
   logic         sb_tx_ready;
   logic [31:0]  words_sent;

   int errors = 0;
   int checks = 0;

   logic [255:0] q_data [$];
   logic [31:0]  q_dest [$];
   logic         q_last [$];

   sb_tx_packer dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_last     (in_last),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .cfg_dest    (cfg_dest),
      .sb_tx_data  (sb_tx_data),
      .sb_tx_dest  (sb_tx_dest),
      .sb_tx_last  (sb_tx_last),
      .sb_tx_valid (sb_tx_valid),
      .sb_tx_ready (sb_tx_ready),
      .words_sent  (words_sent)
   );

   always #5 clk = ~clk;

   // Record every word that will be accepted on the next rising edge.
   always @(negedge clk) begin
      if (!reset && sb_tx_valid && sb_tx_ready) begin
         q_data.push_back(sb_tx_data);
         q_dest.push_back(sb_tx_dest);
         q_last.push_back(sb_tx_last);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   function automatic logic [255:0] pat(input int start, input int cnt);
      logic [255:0] r;
      r = '0;
      for (int k = 0; k < cnt; k++)
         r[k*8 +: 8] = 8'(start + k);
      return r;
   endfunction

   task automatic push(input logic [7:0] d, input logic l);
      int t;
      t = 0;
      in_data  = d;
      in_last  = l;
      in_valid = 1'b1;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 200) begin
         errors++;
         $display("FAIL push_timeout: in_ready got 0 after %0d cycles, expected 1", t);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_words(input int n);
      int t;
      t = 0;
      while (q_data.size() < n && t < 500) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      checks++;
      if (q_data.size() != n) begin
         errors++;
         $display("FAIL word_count: got %0d words, expected %0d", q_data.size(), n);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (sb_tx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", sb_tx_valid); end
      checks++;
      if (sb_tx_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b expected 0", sb_tx_last); end
      checks++;
      if (sb_tx_dest !== 32'd0) begin errors++; $display("FAIL rst_dest: got %h expected 0", sb_tx_dest); end
      checks++;
      if (words_sent !== 32'd0) begin errors++; $display("FAIL rst_words: got %0d expected 0", words_sent); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
      checks++;
      if (sb_tx_data !== 256'd0) begin errors++; $display("FAIL rst_data: got %h expected all PAD", sb_tx_data); end
   endtask

   task automatic test_full_word();
      logic [255:0] d; logic [31:0] ds; logic l;
      cfg_dest = 32'h5;
      for (int i = 0; i < 32; i++)
         push(8'(i), i == 31);
      wait_words(1);
      d = q_data.pop_front(); ds = q_dest.pop_front(); l = q_last.pop_front();
      checks++;
      if (d !== pat(0, 32)) begin errors++; $display("FAIL full_data: got %h expected %h", d, pat(0, 32)); end
      checks++;
      if (ds !== 32'h5) begin errors++; $display("FAIL full_dest: got %h expected 5", ds); end
      checks++;
      if (l !== 1'b1) begin errors++; $display("FAIL full_last: got %b expected 1", l); end
      checks++;
      if (words_sent !== 32'd1) begin errors++; $display("FAIL full_words: got %0d expected 1", words_sent); end
   endtask

   task automatic test_short();
      logic [255:0] d; logic l;
      push(8'hAA, 1'b0);
      push(8'hBB, 1'b0);
      push(8'hCC, 1'b1);
      checks++;
      if (sb_tx_valid !== 1'b1) begin errors++; $display("FAIL short_latency: valid got %b expected 1", sb_tx_valid); end
      wait_words(1);
      d = q_data.pop_front(); void'(q_dest.pop_front()); l = q_last.pop_front();
      checks++;
      if (d !== 256'hCCBBAA) begin errors++; $display("FAIL short_data: got %h expected %h", d, 256'hCCBBAA); end
      checks++;
      if (l !== 1'b1) begin errors++; $display("FAIL short_last: got %b expected 1", l); end
      checks++;
      if (words_sent !== 32'd2) begin errors++; $display("FAIL short_words: got %0d expected 2", words_sent); end
   endtask

   task automatic test_multi_word();
      logic [255:0] d; logic [31:0] ds; logic l;
      logic [255:0] exp_d [3];
      logic         exp_l [3];
      exp_d[0] = pat(0, 32);  exp_l[0] = 1'b0;
      exp_d[1] = pat(32, 32); exp_l[1] = 1'b0;
      exp_d[2] = pat(64, 6);  exp_l[2] = 1'b1;
      for (int i = 0; i < 70; i++)
         push(8'(i), i == 69);
      wait_words(3);
      for (int w = 0; w < 3; w++) begin
         d = q_data.pop_front(); ds = q_dest.pop_front(); l = q_last.pop_front();
         checks++;
         if (d !== exp_d[w]) begin errors++; $display("FAIL multi_data%0d: got %h expected %h", w, d, exp_d[w]); end
         checks++;
         if (l !== exp_l[w]) begin errors++; $display("FAIL multi_last%0d: got %b expected %b", w, l, exp_l[w]); end
         checks++;
         if (ds !== 32'h5) begin errors++; $display("FAIL multi_dest%0d: got %h expected 5", w, ds); end
      end
      checks++;
      if (words_sent !== 32'd5) begin errors++; $display("FAIL multi_words: got %0d expected 5", words_sent); end
   endtask

   task automatic test_backpressure();
      logic [255:0] d; logic [31:0] ds; logic l;
      sb_tx_ready = 1'b0;
      cfg_dest    = 32'h9;
      for (int i = 0; i < 4; i++)
         push(8'(8'h10 + i), i == 3);
      fork
         begin
            push(8'h21, 1'b0);
            push(8'h22, 1'b1);
         end
         begin
            for (int c = 0; c < 10; c++) begin
               @(negedge clk);
               checks++;
               if ({sb_tx_valid, sb_tx_last, sb_tx_dest, sb_tx_data} !== {1'b1, 1'b1, 32'h9, pat(16, 4)}) begin
                  errors++;
                  $display("FAIL hold_word c%0d: got v=%b l=%b dest=%h data=%h expected v=1 l=1 dest=9 data=%h",
                           c, sb_tx_valid, sb_tx_last, sb_tx_dest, sb_tx_data, pat(16, 4));
               end
`ifndef SB_TX_PACKER_SKID_EN
               checks++;
               if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready c%0d: got %b expected 0", c, in_ready); end
`endif
            end
            @(posedge clk);
            #1;
            sb_tx_ready = 1'b1;
         end
      join
      wait_words(2);
      d = q_data.pop_front(); ds = q_dest.pop_front(); l = q_last.pop_front();
      checks++;
      if (d !== pat(16, 4)) begin errors++; $display("FAIL bp_data0: got %h expected %h", d, pat(16, 4)); end
      d = q_data.pop_front(); ds = q_dest.pop_front(); l = q_last.pop_front();
      checks++;
      if (d !== 256'h2221) begin errors++; $display("FAIL bp_data1: got %h expected %h", d, 256'h2221); end
      checks++;
      if ({ds, l} !== {32'h9, 1'b1}) begin errors++; $display("FAIL bp_tag1: got dest=%h last=%b expected dest=9 last=1", ds, l); end
      checks++;
      if (words_sent !== 32'd7) begin errors++; $display("FAIL bp_words: got %0d expected 7", words_sent); end
   endtask

   task automatic test_dest_switch();
      logic [31:0] ds;
      logic [31:0] exp_ds [3];
      exp_ds[0] = 32'h1; exp_ds[1] = 32'h1; exp_ds[2] = 32'h2;
      cfg_dest = 32'h1;
      for (int i = 0; i < 40; i++) begin
         if (i == 5)
            cfg_dest = 32'h2;
         push(8'(8'h40 + i), i == 39);
      end
      push(8'h99, 1'b1);
      wait_words(3);
      for (int w = 0; w < 3; w++) begin
         ds = q_dest.pop_front(); void'(q_data.pop_front()); void'(q_last.pop_front());
         checks++;
         if (ds !== exp_ds[w]) begin errors++; $display("FAIL dest_switch%0d: got %h expected %h", w, ds, exp_ds[w]); end
      end
      checks++;
      if (words_sent !== 32'd10) begin errors++; $display("FAIL dest_words: got %0d expected 10", words_sent); end
   endtask

   task automatic test_reset_mid();
      logic [255:0] d; logic [31:0] ds; logic l;
      cfg_dest = 32'h3;
      for (int i = 0; i < 10; i++)
         push(8'(8'hE0 + i), 1'b0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if (words_sent !== 32'd0) begin errors++; $display("FAIL mid_rst_words: got %0d expected 0", words_sent); end
      checks++;
      if (sb_tx_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", sb_tx_valid); end
      push(8'h7E, 1'b1);
      wait_words(1);
      d = q_data.pop_front(); ds = q_dest.pop_front(); l = q_last.pop_front();
      checks++;
      if (d !== 256'h7E) begin errors++; $display("FAIL mid_data: got %h expected %h", d, 256'h7E); end
      checks++;
      if ({ds, l} !== {32'h3, 1'b1}) begin errors++; $display("FAIL mid_tag: got dest=%h last=%b expected dest=3 last=1", ds, l); end
      checks++;
      if (words_sent !== 32'd1) begin errors++; $display("FAIL mid_words: got %0d expected 1", words_sent); end
   endtask

   initial begin
      reset       = 1'b1;
      in_data     = 8'h00;
      in_last     = 1'b0;
      in_valid    = 1'b0;
      cfg_dest    = 32'h0;
      sb_tx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_full_word();
      test_short();
      test_multi_word();
      test_backpressure();
      test_dest_switch();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sb_tx_packer.md
Name: sb_tx_packer

Overview:
- Transmit-side packetizer for the switchboard TX path: it packs a narrow lane stream (default byte-wide) into 256-bit SB words.
- Output uses SB valid/ready/last/dest signalling, ready to drive an SB_TO_QUEUE TX port.
- It is the producer counterpart of the blocks that consume SB RX words and unpack them into lanes.
- Sits between a user data source and the SB TX queue bridge.

Parameters:
DW, 256, SB data width in bits; must be a multiple of IW
IW, 8, input lane width in bits
DESTW, 32, SB dest field width
PAD, 8'h00, fill value for unused lanes of a short final word (IW bits)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_data  input  IW  input lane
in_last  input  1  final lane of the packet
in_valid  input  1  input lane valid
in_ready  output  1  packer can accept a lane
cfg_dest  input  DESTW  destination, sampled on the first lane of each packet
sb_tx_data  output  DW  packed SB word
sb_tx_dest  output  DESTW  SB destination
sb_tx_last  output  1  word ends the packet
sb_tx_valid  output  1  word valid
sb_tx_ready  input  1  downstream accept
words_sent  output  32  count of SB words handed off

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All state is registered.
- N = DW/IW lanes per word. Lane index idx is $clog2(N) bits.
- Lane k occupies sb_tx_data[k*IW +: IW]. The first lane received goes in lane 0.
- Reset values:
  - state = FILL, idx = 0, word buffer = all PAD.
  - sb_tx_valid = 0, sb_tx_last = 0, sb_tx_dest = 0, words_sent = 0, first_lane flag = 1.
- FILL state:
  - in_ready = 1.
  - When in_valid is high, write in_data to lane idx.
  - If first_lane is set: latch cfg_dest into the dest register and clear first_lane.
  - If idx == N-1 or in_last: go to SEND next cycle with sb_tx_last = in_last and idx cleared. Otherwise idx increments.
- SEND state:
  - in_ready = 0. sb_tx_valid = 1.
  - Data, dest and last are held stable until accepted.
  - On sb_tx_ready: words_sent increments (wraps at 2^32), the buffer refills with PAD, and state returns to FILL.
  - If sb_tx_last was 1, first_lane is set again.
- Latency: the word is valid on the cycle after the filling lane is accepted.
- Base throughput: N lanes plus one SEND cycle per word (minimum, with sb_tx_ready held high).
- Boundary cases:
  - in_last on lane N-1 produces exactly one word with last=1; no empty trailing word.
  - in_last on lane 0 produces one word: lane 0 holds the data, lanes 1..N-1 hold PAD.
  - sb_tx_ready may be high before valid; it has no effect in FILL.
  - sb_tx_valid never deasserts without a handshake.
- Reset mid-packet discards the partial word and any pending word. The next lane accepted starts a new packet.
- cfg_dest changes mid-packet are ignored until the next packet's first lane.

Optional Feature:
- Macro SB_TX_PACKER_SKID_EN.
- Defined:
  - Adds a second word buffer (ping-pong). Filling continues while the other buffer is in SEND.
  - in_ready = 0 only when both buffers are full.
  - Sustains one lane per cycle with sb_tx_ready held high; words are issued strictly in fill order.
  - dest and last are stored per buffer.
- Undefined: single-buffer behaviour exactly as above.

Decomposition:
- Package sb_tx_packer_pkg holds:
  - state enum {FILL, SEND};
  - SB_DW = 256 and SB_DESTW = 32 constants;
  - packed struct word_t {data, dest, last}.
- One natural sub-module, sb_tx_packer_wbuf: a single word buffer holding a word_t, with lane-write, clear-to-PAD and valid flag. It is instantiated once, or twice under SB_TX_PACKER_SKID_EN.

Test Plan:
- Packet of 32 lanes 0x00..0x1F, cfg_dest=0x5, sb_tx_ready=1 -> one word: byte k = k, dest=5, last=1, words_sent=1.
- Packet of 3 lanes 0xAA,0xBB,0xCC -> bytes 0..2 = AA,BB,CC; bytes 3..31 = 0x00; last=1.
- 70-lane packet -> 3 words: last=0, last=0, last=1; third word has 6 valid bytes plus 26 PAD bytes; words_sent=3.
- sb_tx_ready held low 10 cycles during SEND -> data, dest and last stable; in_ready=0 (single buffer); no lanes lost after release.
- cfg_dest switched 1->2 mid-packet -> all words of that packet carry dest=1; the next packet carries dest=2.
- reset asserted after 10 lanes, then a 1-lane packet 0x7E -> a single word with byte0 = 0x7E and the rest PAD; no stale bytes; words_sent restarts at 0.
